wb_queue: RTL
=============

# wb_queue

Writeback sequencer that sits directly upstream of the register file's single write port. It merges single-cycle ALU results with multi-cycle load results arriving over a valid/ready handshake. Load results are buffered in a small in-order queue whenever the ALU owns the port. It also provides a bypass lookup so operand reads see pending, not-yet-written load data.

## Interface
- addr_width_p, 6: register address width; must match the register file.
- W1, 32: data width.
- depth_p, 4: load queue entries; power of two, ≥2.

- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- alu_valid_i  input  1  ALU result present this cycle; always accepted.
- alu_rd_i  input  addr_width_p  ALU destination register.
- alu_data_i  input  W1  ALU result.
- ld_valid_i  input  1  load result offered.
- ld_ready_o  output  1  queue can accept a load result (= not full).
- ld_rd_i  input  addr_width_p  load destination register.
- ld_data_i  input  W1  load data.
- wen_o  output  1  register file write enable.
- rd_addr_o  output  addr_width_p  register file write address.
- write_data_o  output  W1  register file write data.
- byp_addr_i  input  addr_width_p  bypass lookup address.
- byp_hit_o  output  1  a live queued entry targets byp_addr_i.
- byp_data_o  output  W1  data of the youngest live matching entry; 0 when no hit.

## Operation
- Storage: depth_p entries {live, rd, data}; head/tail pointers of log2(depth_p) bits wrap modulo depth_p; count is log2(depth_p)+1 bits, 0..depth_p.
- Load handshake: a transfer occurs when ld_valid_i && ld_ready_o. The entry is written at tail with live=1, and tail increments. Producer holds rd/data stable while valid && !ready.
- Write port priority, evaluated combinationally each cycle:
  - alu_valid_i: wen_o=1 with ALU addr/data. Queue does not pop.
  - Otherwise, if count>0: pop head. wen_o=head.live, addr/data from head.
  - Otherwise wen_o=0. rd_addr_o and write_data_o are 0.
- Kill rule: when alu_valid_i, every entry already in the queue with rd==alu_rd_i has live cleared at the edge. This keeps a stale load from overwriting a newer ALU result. Killed entries still pop in order, with wen_o=0.
- Same-cycle ALU write and load accept to the same rd: the incoming load is younger and is enqueued live.
- Pop and push in the same cycle: both happen, and count is unchanged. A push is allowed when full only if not full at the start of the cycle. ld_ready_o does not look ahead at the pop.
- Bypass: byp_hit_o is 1 if any live entry has rd==byp_addr_i. The youngest such entry (closest to tail) supplies the data. Bypass is purely combinational on current state. It does not see this cycle's incoming load or ALU data.

## Timing
- Reset values: queue empty, all live=0, pointers 0. Outputs: wen_o=0, rd_addr_o=0, write_data_o=0, byp_hit_o=0, byp_data_o=0, ld_ready_o=1 (not full).
- ALU path latency is 0 cycles, from input to wen_o in the same cycle.
- Load path: minimum 1 cycle from accept to wen_o, when the queue is empty and no ALU write is present. Each entry ahead of it and each ALU write cycle adds 1 cycle.
- ld_ready_o is 0 exactly when count==depth_p.
- Reset asserted mid-operation discards all queued entries. No write is issued for them.

## Structure
- Shared package wb_pkg: typedef wb_entry_s {live, rd, data}, parametrised through the module widths; and constant WB_DEPTH_DEFAULT=4.
- One natural sub-module: wb_fifo_ctrl, which owns the head/tail/count pointers and produces full/empty/push/pop. Entry storage, the kill logic and the bypass search stay in wb_queue.

## Test plan
- Reset: assert reset mid-stream with 3 entries queued. Require all outputs at reset values, ld_ready_o=1, and no writes after release.
- Empty bypass: load rd=5, data=0xAAAA_0001 with no ALU traffic. Next cycle require wen_o=1, rd_addr_o=5, write_data_o=0xAAAA_0001, and byp_hit_o=0 afterwards.
- Fill: hold alu_valid_i=1 (rd=1) for 6 cycles while offering loads rd=10..15. Require ld_ready_o=0 after 4 accepts. After the ALU stops, require writes rd=10,11,12,13 in order, then 14,15.
- Kill: queue a load rd=7, data=0x11. Then ALU writes rd=7, data=0x22. Require the ALU write to occur, the later pop of the load to show wen_o=0, and byp_hit_o(7)=0 after the kill edge.
- Youngest-wins bypass: queue rd=3/0x30 then rd=3/0x31 while the ALU is busy. Require byp_addr_i=3 to give byp_hit_o=1 and byp_data_o=0x31.
- Wrap: run 10 push/pop cycles with depth_p=4 and simultaneous push+pop. Require in-order writes, count stable, and no spurious full.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared entry type and constants for the writeback queue
package wb_pkg;

  localparam int WB_DEPTH_DEFAULT  = 4;
  localparam int WB_ADDR_W_DEFAULT = 6;
  localparam int WB_DATA_W_DEFAULT = 32;

  // Default-width view of one queue slot; wb_queue re-derives it from its own widths.
  typedef struct packed {
    logic                         live;
    logic [WB_ADDR_W_DEFAULT-1:0] rd;
    logic [WB_DATA_W_DEFAULT-1:0] data;
  } wb_entry_s;

endpackage

// File: rtl/wb_fifo_ctrl.sv
// rtl/wb_fifo_ctrl.sv - head/tail/count bookkeeping for the load queue
module wb_fifo_ctrl
  import wb_pkg::*;
#(
  parameter  int depth_p = WB_DEPTH_DEFAULT,
  localparam int PTR_W   = $clog2(depth_p)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_req_i,
  input  logic             pop_req_i,
  output logic             push_o,
  output logic             pop_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W-1:0] head_o,
  output logic [PTR_W-1:0] tail_o
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  // Full is judged on start-of-cycle state only; a same-cycle pop does not open a slot.
  assign full_o  = (r_count == (PTR_W+1)'(depth_p));
  assign empty_o = (r_count == '0);
  assign push_o  = push_req_i && !full_o;
  assign pop_o   = pop_req_i && !empty_o;
  assign head_o  = r_head;
  assign tail_o  = r_tail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push_o) begin
        r_tail <= r_tail + 1'b1;
      end
      if (pop_o) begin
        r_head <= r_head + 1'b1;
      end
      case ({push_o, pop_o})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - merges ALU and queued load results onto the register file write port
module wb_queue
  import wb_pkg::*;
#(
  parameter int addr_width_p = WB_ADDR_W_DEFAULT,
  parameter int W1           = WB_DATA_W_DEFAULT,
  parameter int depth_p      = WB_DEPTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid_i,
  input  logic [addr_width_p-1:0] alu_rd_i,
  input  logic [W1-1:0]           alu_data_i,
  input  logic                    ld_valid_i,
  output logic                    ld_ready_o,
  input  logic [addr_width_p-1:0] ld_rd_i,
  input  logic [W1-1:0]           ld_data_i,
  output logic                    wen_o,
  output logic [addr_width_p-1:0] rd_addr_o,
  output logic [W1-1:0]           write_data_o,
  input  logic [addr_width_p-1:0] byp_addr_i,
  output logic                    byp_hit_o,
  output logic [W1-1:0]           byp_data_o
);

  localparam int PTR_W = $clog2(depth_p);

  typedef struct packed {
    logic                    live;
    logic [addr_width_p-1:0] rd;
    logic [W1-1:0]           data;
  } wb_entry_t;

  wb_entry_t        r_q [depth_p];
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_pop_req;
  logic [PTR_W-1:0] w_head;
  logic [PTR_W-1:0] w_tail;
  logic [PTR_W-1:0] w_idx;

  assign w_pop_req  = !alu_valid_i;
  assign ld_ready_o = !w_full;

  wb_fifo_ctrl #(
    .depth_p (depth_p)
  ) u_fifo_ctrl (
    .clk        (clk),
    .reset      (reset),
    .push_req_i (ld_valid_i),
    .pop_req_i  (w_pop_req),
    .push_o     (w_push),
    .pop_o      (w_pop),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .head_o     (w_head),
    .tail_o     (w_tail)
  );

  // Kill first, then retire head, then enqueue: a same-cycle load to the ALU's rd stays live.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < depth_p; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      if (alu_valid_i) begin
        for (int i = 0; i < depth_p; i++) begin
          if (r_q[i].rd == alu_rd_i) begin
            r_q[i].live <= 1'b0;
          end
        end
      end
      if (w_pop) begin
        r_q[w_head].live <= 1'b0;
      end
      if (w_push) begin
        r_q[w_tail] <= '{live: 1'b1, rd: ld_rd_i, data: ld_data_i};
      end
    end
  end

  always_comb begin
    wen_o        = 1'b0;
    rd_addr_o    = '0;
    write_data_o = '0;
    if (alu_valid_i) begin
      wen_o        = 1'b1;
      rd_addr_o    = alu_rd_i;
      write_data_o = alu_data_i;
    end else if (!w_empty) begin
      wen_o        = r_q[w_head].live;
      rd_addr_o    = r_q[w_head].rd;
      write_data_o = r_q[w_head].data;
    end
  end

  // Scan oldest to youngest so the last match, nearest the tail, wins.
  always_comb begin
    byp_hit_o  = 1'b0;
    byp_data_o = '0;
    w_idx      = '0;
    for (int i = 0; i < depth_p; i++) begin
      w_idx = w_head + PTR_W'(i);
      if (r_q[w_idx].live && (r_q[w_idx].rd == byp_addr_i)) begin
        byp_hit_o  = 1'b1;
        byp_data_o = r_q[w_idx].data;
      end
    end
  end

endmodule
